// File: rtl/mem_pkg.sv
// Shared definitions for the core's unified-memory access path: response
// owner encoding, default address width and byte-lane constants.
package mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;

    // Which requester the read data returning next cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    // Counter width able to hold 0..max_count; never narrower than one bit.
    function automatic int streak_w(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/streak_counter.sv
// Saturating event counter with synchronous clear and an at-max flag.
// Used by the memory arbiter to bound how long one requester can be
// starved by the other.
module streak_counter
    import mem_pkg::*;
#(
    parameter int MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int                CNT_W   = streak_w(MAX_COUNT);
    localparam logic [CNT_W-1:0]  MAX_VAL = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] r_count;

    // Count up on i_inc, stop at MAX_VAL; clear wins over increment.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_at_max = (r_count == MAX_VAL);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing the single-port unified memory between instruction fetch
// and the load/store unit. Data wins conflicts, except that after
// MAX_D_STREAK consecutive data grants with a fetch waiting, the fetch is
// forced through. One grant per cycle, read data returns one cycle later and
// is steered to whichever requester was granted.
module imem_dmem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,

    // instruction fetch port
    input  logic                i_req,
    input  logic [31:0]         i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [31:0]         i_rdata,

    // load/store port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [BE_W-1:0]     d_be,
    input  logic [31:0]         d_addr,
    input  logic [31:0]         d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [31:0]         d_rdata,

    // memory port
    output logic                m_en,
    output logic                m_we,
    output logic [BE_W-1:0]     m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [31:0]         m_wdata,
    input  logic [31:0]         m_rdata
);

    logic   w_i_gnt;
    logic   w_d_gnt;
    logic   w_fetch_due;
    logic   w_streak_inc;
    logic   w_streak_clr;
    owner_e r_owner;

    // Byte-offset bits and address bits above the memory depth are dropped on
    // purpose so out-of-range addresses wrap; gather them so it is explicit.
    logic   w_unused_addr_bits;
    assign w_unused_addr_bits = ^{i_addr[1:0], i_addr[31:ADDR_W+2],
                                  d_addr[1:0], d_addr[31:ADDR_W+2]};

    // Consecutive data grants taken while a fetch is waiting.
    streak_counter #(
        .MAX_COUNT (MAX_D_STREAK)
    ) u_streak (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_streak_inc),
        .i_clr    (w_streak_clr),
        .o_at_max (w_fetch_due)
    );

    assign w_streak_inc = w_d_gnt & i_req;
    assign w_streak_clr = w_i_gnt | ~i_req;

    // Grant selection: data-over-fetch unless the fetch has waited long enough.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (w_fetch_due) begin
                    w_i_gnt = 1'b1;
                end else begin
                    w_d_gnt = 1'b1;
                end
            end else begin
                w_i_gnt = i_req;
                w_d_gnt = d_req;
            end
        end
    end

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    // Memory address from the winner; zero when nobody is granted.
    always_comb begin
        m_addr = '0;
        if (w_d_gnt) begin
            m_addr = d_addr[ADDR_W+1:2];
        end else if (w_i_gnt) begin
            m_addr = i_addr[ADDR_W+1:2];
        end
    end

    assign m_en    = w_i_gnt | w_d_gnt;
    assign m_we    = w_d_gnt & d_we;
    assign m_be    = (w_d_gnt & d_we) ? d_be : '0;
    assign m_wdata = m_en ? d_wdata : '0;

    // Remember who owns the read data arriving next cycle; writes return nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else if (w_i_gnt) begin
            r_owner <= OWN_FETCH;
        end else if (w_d_gnt && !d_we) begin
            r_owner <= OWN_DATA;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    assign i_rvalid = (r_owner == OWN_FETCH);
    assign d_rvalid = (r_owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: behavioural memory, a directed
// vector table, hand-written multi-cycle sequences and a randomized phase
// checked against a transaction-level reference model.
module tb_imem_dmem_arbiter;
    import mem_pkg::*;

    localparam int AW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int MAXS  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic [AW-1:0] m_addr;

    // second instance: fetch wins every conflict
    logic        z_i_gnt, z_i_rvalid, z_d_gnt, z_d_rvalid, z_m_en, z_m_we;
    logic [31:0] z_i_rdata, z_d_rdata, z_m_wdata;
    logic [3:0]  z_m_be;
    logic [AW-1:0] z_m_addr;

    int n_checks = 0;
    int n_fail   = 0;

    imem_dmem_arbiter #(.ADDR_W(AW), .MAX_D_STREAK(MAXS)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    imem_dmem_arbiter #(.ADDR_W(AW), .MAX_D_STREAK(0)) u_dut_s0 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(z_i_gnt), .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
        .m_en(z_m_en), .m_we(z_m_we), .m_be(z_m_be), .m_addr(z_m_addr), .m_wdata(z_m_wdata),
        .m_rdata(m_rdata)
    );

    function automatic logic [31:0] init_word(input int k);
        if (k < 3)       return 32'h0000_0013;
        if (k == 'h800)  return 32'h1122_3344;
        return 32'hD00D_0000 | 32'(k);
    endfunction

    // Behavioural single-port memory (1-cycle read latency); reloaded on reset.
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= init_word(k);
            m_rdata <= 32'h0;
        end else begin
            if (m_en && m_we)
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            if (m_en && !m_we) m_rdata <= mem[m_addr];
            else               m_rdata <= $urandom;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_streak  = 0;
    logic        pend_i    = 1'b0;
    logic        pend_d    = 1'b0;
    logic [31:0] pend_data = 32'h0;
    logic        last_ig   = 1'b0;
    logic        last_dg   = 1'b0;
    logic        prev_i_req = 1'b0, prev_d_req = 1'b0;
    logic [31:0] prev_i_addr = 32'h0, prev_d_addr = 32'h0, prev_d_wdata = 32'h0;
    logic [4:0]  prev_d_ctl = 5'h0;

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return AW'((a >> 2) % DEPTH);
    endfunction

    // Called mid-cycle with inputs stable: compare, advance the model, move
    // to just after the next rising edge.
    task automatic model_cycle();
        logic          e_ig, e_dg;
        logic [AW-1:0] e_word;
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (m_streak >= MAXS) e_ig = 1'b1;
                else                  e_dg = 1'b1;
            end else begin
                e_ig = i_req;
                e_dg = d_req;
            end
        end
        e_word = e_dg ? word_of(d_addr) : (e_ig ? word_of(i_addr) : '0);

        check("i_gnt",    32'(i_gnt),    32'(e_ig));
        check("d_gnt",    32'(d_gnt),    32'(e_dg));
        check("m_en",     32'(m_en),     32'(e_ig | e_dg));
        check("m_addr",   32'(m_addr),   32'(e_word));
        check("m_we",     32'(m_we),     32'(e_dg & d_we));
        check("m_be",     32'(m_be),     (e_dg && d_we) ? 32'(d_be) : 32'h0);
        check("m_wdata",  m_wdata,       (e_ig | e_dg) ? d_wdata : 32'h0);
        check("i_rvalid", 32'(i_rvalid), 32'(pend_i));
        check("d_rvalid", 32'(d_rvalid), 32'(pend_d));
        check("i_rdata",  i_rdata,       pend_i ? pend_data : 32'h0);
        check("d_rdata",  d_rdata,       pend_d ? pend_data : 32'h0);

        // stimulus must hold a request unchanged until it is granted
        if (prev_i_req && !last_ig && i_req)
            check("hold_i_addr", i_addr, prev_i_addr);
        if (prev_d_req && !last_dg && d_req) begin
            check("hold_d_addr",  d_addr,  prev_d_addr);
            check("hold_d_wdata", d_wdata, prev_d_wdata);
            check("hold_d_ctl",   32'({d_we, d_be}), 32'(prev_d_ctl));
        end

        if (rst) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);
            m_streak = 0;
            pend_i   = 1'b0;
            pend_d   = 1'b0;
        end else begin
            pend_i    = e_ig;
            pend_d    = e_dg && !d_we;
            pend_data = ref_mem[e_word];
            if (e_dg && d_we)
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ref_mem[e_word][8*b +: 8] = d_wdata[8*b +: 8];
            if (e_ig || !i_req) m_streak = 0;
            else if (e_dg)      m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
        end
        last_ig      = e_ig;
        last_dg      = e_dg;
        prev_i_req   = i_req;
        prev_i_addr  = i_addr;
        prev_d_req   = d_req;
        prev_d_addr  = d_addr;
        prev_d_wdata = d_wdata;
        prev_d_ctl   = {d_we, d_be};
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[17:2] = 16'($urandom_range(31));
        return a;
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic we, input logic [3:0] be,
                         input logic [31:0] da, input logic [31:0] wd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        i_req;  logic [31:0] i_addr;
        logic        d_req;  logic        d_we;   logic [3:0] d_be;
        logic [31:0] d_addr; logic [31:0] d_wdata;
        logic        e_ig;   logic        e_dg;   logic [15:0] e_maddr;
        logic        e_mwe;  logic [3:0]  e_mbe;
        logic        e_irv;  logic [31:0] e_irdata;
        logic        e_drv;  logic [31:0] e_drdata;
    } vec_t;

    vec_t vecs [10];
    string seq;

    initial begin
        //           ireq iaddr          dreq we be      daddr          wdata           ig dg maddr     mwe mbe     irv irdata         drv drdata
        vecs[0] = '{1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 16'h0,    1'b0, 4'h0,    1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 16'h0,    1'b0, 4'h0,    1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h4,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 16'h1,    1'b0, 4'h0,    1'b1, 32'h13,        1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h8,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 16'h2,    1'b0, 4'h0,    1'b1, 32'h13,        1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h8,         1'b1, 1'b0, 4'h0, 32'h0004_0004, 32'h0,         1'b0, 1'b1, 16'h1,    1'b0, 4'h0,    1'b1, 32'h13,        1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'h9, 32'h10,        32'hCAFE_F00D, 1'b0, 1'b1, 16'h4,    1'b1, 4'h9,    1'b0, 32'h0,         1'b1, 32'h13};
        vecs[6] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 16'hFFFF, 1'b0, 4'h0,    1'b0, 32'h0,         1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 16'h0,    1'b0, 4'h0,    1'b1, 32'hD00D_FFFF, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h10,        32'h0,         1'b0, 1'b1, 16'h4,    1'b0, 4'h0,    1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9] = '{1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 16'h0,    1'b0, 4'h0,    1'b0, 32'h0,         1'b1, 32'hCA0D_000D};

        // ---- reset: outputs quiet even with both requests raised ----
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        check("rst_i_gnt",    32'(i_gnt),    32'h0);
        check("rst_d_gnt",    32'(d_gnt),    32'h0);
        check("rst_m_en",     32'(m_en),     32'h0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        model_cycle();
        rst = 1'b0;

        // ---- directed table: fetch stream, wrap, byte write, read-back ----
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req, vecs[v].d_we,
                  vecs[v].d_be, vecs[v].d_addr, vecs[v].d_wdata);
            @(negedge clk);
            check($sformatf("vec%0d_i_gnt", v),    32'(i_gnt),    32'(vecs[v].e_ig));
            check($sformatf("vec%0d_d_gnt", v),    32'(d_gnt),    32'(vecs[v].e_dg));
            check($sformatf("vec%0d_m_en", v),     32'(m_en),     32'(vecs[v].e_ig | vecs[v].e_dg));
            check($sformatf("vec%0d_m_addr", v),   32'(m_addr),   32'(vecs[v].e_maddr));
            check($sformatf("vec%0d_m_we", v),     32'(m_we),     32'(vecs[v].e_mwe));
            check($sformatf("vec%0d_m_be", v),     32'(m_be),     32'(vecs[v].e_mbe));
            check($sformatf("vec%0d_i_rvalid", v), 32'(i_rvalid), 32'(vecs[v].e_irv));
            check($sformatf("vec%0d_i_rdata", v),  i_rdata,       vecs[v].e_irdata);
            check($sformatf("vec%0d_d_rvalid", v), 32'(d_rvalid), 32'(vecs[v].e_drv));
            check($sformatf("vec%0d_d_rdata", v),  d_rdata,       vecs[v].e_drdata);
            model_cycle();
        end

        // ---- byte write then immediate read-back of the same word ----
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h2000, 32'hAABB_CCDD);
        @(negedge clk);
        model_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h2000, 32'h0);
        @(negedge clk);
        check("raw_no_rvalid_for_write", 32'(d_rvalid), 32'h0);
        model_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("raw_d_rvalid", 32'(d_rvalid), 32'h1);
        check("raw_d_rdata",  d_rdata,       32'h1122_CC44);
        model_cycle();

        // ---- sustained conflict: starvation guard, and the fetch-first instance ----
        seq = "";
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
            @(negedge clk);
            seq = {seq, i_gnt ? "I" : (d_gnt ? "D" : "-")};
            check($sformatf("s0_i_gnt_c%0d", c), 32'(z_i_gnt), 32'h1);
            check($sformatf("s0_d_gnt_c%0d", c), 32'(z_d_gnt), 32'h0);
            model_cycle();
        end
        n_checks++;
        if (seq != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL grant_sequence: got %s, expected DDDDIDDDDI", seq);
        end
        drive(1'b0, 32'h40, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        check("s0_d_gnt_no_fetch", 32'(z_d_gnt), 32'h1);
        check("s0_i_gnt_no_fetch", 32'(z_i_gnt), 32'h0);
        model_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        model_cycle();

        // ---- reset lands on the edge that would have registered a read ----
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
        @(negedge clk);
        check("rstmid_d_gnt", 32'(d_gnt), 32'h1);
        rst   = 1'b1;
        d_req = 1'b0;
        #1;
        model_cycle();
        rst = 1'b0;
        drive(1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstmid_d_rvalid", 32'(d_rvalid), 32'h0);
        check("rstmid_fetch_gnt", 32'(i_gnt),   32'h1);
        check("rstmid_fetch_addr", 32'(m_addr), 32'h11);
        model_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstmid_fetch_data", i_rdata, 32'hD00D_0011);
        model_cycle();

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 3000; n++) begin
            if (i_req && !last_ig) begin
                if ($urandom_range(7) == 0) i_req = 1'b0;
            end else begin
                i_req  = ($urandom_range(3) != 0);
                i_addr = rand_addr();
            end
            if (d_req && !last_dg) begin
                if ($urandom_range(7) == 0) d_req = 1'b0;
            end else begin
                d_req   = ($urandom_range(3) != 0);
                d_we    = ($urandom_range(1) == 1);
                d_be    = 4'($urandom_range(15));
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            @(negedge clk);
            model_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
